// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory request/response channel plus the decode-facing
// instruction port. master = fetch unit, slave = memory/decode side.
interface inst_fetch_unit_if #(parameter int ADDR_W = 10);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              imem_rsp_err;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: one outstanding word read per PC, instruction held for decode until consumed.
// Best case 3 cycles per instruction; request held until imem_req_ready, pc held via pc_hold.
module inst_fetch_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int          ADDR_W    = 10,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              flush,
  output logic              pc_hold,
  inst_fetch_unit_if.master bus,
  output logic              fault,
  output logic [31:0]       fault_pc
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DROP  = 3'd4;
  localparam logic [2:0] FAULT = 3'd5;

  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd4 << ADDR_W);
  localparam logic [7:0]  TMO_MAX  = 8'(TIMEOUT);

  logic [2:0]  state;
  logic [31:0] req_pc;
  logic [7:0]  tmo_cnt;
  logic        addr_ok;
  logic        req_fire;
  logic        consume;
  logic        tmo_hit;

  assign addr_ok = (pc[1:0] == 2'b00) && (pc >= BASE_ADDR) && ({1'b0, pc} < END_ADDR);
  assign bus.imem_req_valid = (state == REQ) && addr_ok;
  assign bus.imem_req_addr  = bus.imem_req_valid ? ADDR_W'((pc - BASE_ADDR) >> 2) : '0;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign consume  = bus.inst_valid && bus.inst_ready;
  assign pc_hold  = ~(consume | flush);
  assign tmo_hit  = (tmo_cnt == TMO_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      bus.inst       <= 32'h0;
      bus.inst_pc    <= BASE_ADDR;
      bus.inst_valid <= 1'b0;
      fault          <= 1'b0;
      fault_pc       <= 32'h0;
      tmo_cnt        <= 8'd0;
      req_pc         <= BASE_ADDR;
    end else begin
      if (req_fire) req_pc <= pc;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          tmo_cnt <= 8'd0;
          if (flush) begin
            state <= req_fire ? DROP : REQ;
          end else if (!addr_ok) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
          end else if (req_fire) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            // A response arriving with the flush retires the request, so nothing is left to drop.
            state   <= bus.imem_rsp_valid ? REQ : DROP;
            tmo_cnt <= 8'd0;
          end else if (bus.imem_rsp_valid) begin
            if (bus.imem_rsp_err) begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= req_pc;
            end else begin
              bus.inst       <= bus.imem_rsp_data;
              bus.inst_pc    <= req_pc;
              bus.inst_valid <= 1'b1;
              state          <= HOLD;
            end
          end else if (tmo_hit) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= req_pc;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (flush || bus.inst_ready) begin
            bus.inst_valid <= 1'b0;
            state          <= REQ;
          end
        end
        DROP: begin
          if (bus.imem_rsp_valid) begin
            state <= REQ;
          end else if (tmo_hit) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= req_pc;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized stream checked against
// a program-order model (presented instruction must always be mem[pc] for the held pc).
module tb_inst_fetch_unit;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          AW   = 10;
  localparam int          TMO  = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc    = BASE;
  logic        flush = 1'b0;
  logic        pc_hold;
  logic        fault;
  logic [31:0] fault_pc;

  inst_fetch_unit_if #(.ADDR_W(AW)) bus ();

  inst_fetch_unit #(.BASE_ADDR(BASE), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .pc(pc), .flush(flush), .pc_hold(pc_hold),
    .bus(bus), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          consumed = 0;
  logic [31:0] flush_tgt = BASE;
  bit          auto_mem = 1'b0;
  int          lat_max = 1;
  int          rdy_pct = 100;
  int          req_rdy_pct = 100;
  int          rsp_due[$];
  logic [AW-1:0] rsp_addr[$];

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h9E37_79B9 * (32'(a) + 32'd1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [31:0] p);
    logic [31:0] off;
    off = (p - BASE) / 4;
    return off[AW-1:0];
  endfunction

  // One clock: environment (upstream pc register, memory) reacts to what was seen before the edge.
  task automatic tick();
    bit acc, cons, fl, rs;
    acc  = bus.imem_req_valid && bus.imem_req_ready;
    cons = bus.inst_valid && bus.inst_ready;
    fl   = flush;
    rs   = reset;
    if (auto_mem && bus.imem_rsp_valid && rsp_due.size() > 0) begin
      void'(rsp_due.pop_front());
      void'(rsp_addr.pop_front());
    end
    if (auto_mem && acc) begin
      rsp_due.push_back(cyc + int'($urandom_range(lat_max, 1)));
      rsp_addr.push_back(bus.imem_req_addr);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (rs) pc = BASE;
    else if (fl) pc = flush_tgt;
    else if (cons) begin pc = pc + 32'd4; consumed++; end
    flush = 1'b0;
    if (auto_mem) begin
      bus.imem_rsp_valid = (rsp_due.size() > 0) && (rsp_due[0] <= cyc);
      bus.imem_rsp_data  = (rsp_addr.size() > 0) ? mem_word(rsp_addr[0]) : 32'h0;
      bus.imem_rsp_err   = 1'b0;
      bus.imem_req_ready = ($urandom_range(99) < req_rdy_pct);
      bus.inst_ready     = ($urandom_range(99) < rdy_pct);
    end
  endtask

  task automatic do_reset(input int n);
    auto_mem = 1'b0;
    rsp_due.delete();
    rsp_addr.delete();
    reset = 1'b1;
    flush = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.inst_pc !== BASE) begin errors++; $display("FAIL reset_inst_pc: got %h want %h", bus.inst_pc, BASE); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
    checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault: got %b/%h want 0/0", fault, fault_pc); end
    tick(); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd0) begin
      errors++; $display("FAIL reset_first_req: got v=%b a=%0d want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_fetch_hold();
    logic [31:0] seen;
    do_reset(2);
    flush_tgt = 32'h0040_0008; flush = 1'b1; bus.imem_req_ready = 1'b1; #1;
    tick(); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd2) begin
      errors++; $display("FAIL fetch_req_addr: got v=%b a=%0d want v=1 a=2", bus.imem_req_valid, bus.imem_req_addr); end
    tick(); bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h2402_000A; #1;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid: got %b want 0", bus.inst_valid); end
    tick(); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h2402_000A || bus.inst_pc !== 32'h0040_0008) begin
      errors++; $display("FAIL fetch_present: got v=%b %h@%h want 1 2402000a@00400008", bus.inst_valid, bus.inst, bus.inst_pc); end
    seen = bus.inst;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== seen || pc_hold !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL hold_stable: got v=%b inst=%h hold=%b req=%b want 1 %h 1 0", bus.inst_valid, bus.inst, pc_hold, bus.imem_req_valid, seen); end
    end
    bus.inst_ready = 1'b1; #1;
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL consume_pc_hold: got %b want 0", pc_hold); end
    tick(); bus.inst_ready = 1'b0; #1;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd3) begin
      errors++; $display("FAIL consume_next_req: got v=%b req=%b a=%0d want 0 1 3", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_flush_wait();
    int presented_bad;
    presented_bad = 0;
    do_reset(2);
    bus.imem_req_ready = 1'b1;
    tick(); #1;
    tick(); bus.imem_req_ready = 1'b0; flush_tgt = 32'h0040_0100; flush = 1'b1; #1;
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL flush_pc_hold: got %b want 0", pc_hold); end
    tick(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF; #1;
    if (bus.inst_valid === 1'b1) presented_bad++;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_no_req: got %b want 0", bus.imem_req_valid); end
    tick(); bus.imem_rsp_valid = 1'b0; #1;
    if (bus.inst_valid === 1'b1) presented_bad++;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd64) begin
      errors++; $display("FAIL flush_new_req: got v=%b a=%0d want v=1 a=64", bus.imem_req_valid, bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1; #1;
    tick(); bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0123_4567; #1;
    tick(); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (presented_bad != 0 || bus.inst !== 32'h0123_4567 || bus.inst_pc !== 32'h0040_0100) begin
      errors++; $display("FAIL flush_stale_hidden: got bad=%0d %h@%h want 0 01234567@00400100", presented_bad, bus.inst, bus.inst_pc); end
  endtask

  task automatic test_flush_req_hold();
    do_reset(2);
    tick(); flush_tgt = 32'h0040_0200; flush = 1'b1; #1;
    tick(); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd128) begin
      errors++; $display("FAIL flush_req_retarget: got v=%b a=%0d want v=1 a=128", bus.imem_req_valid, bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1; flush_tgt = 32'h0040_0300; flush = 1'b1; #1;
    tick(); bus.imem_req_ready = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_drop: got %b want 0", bus.imem_req_valid); end
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBAD0_BAD0; #1;
    tick(); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd192 || bus.inst_valid !== 1'b0) begin
      errors++; $display("FAIL drop_then_req: got v=%b a=%0d iv=%b want 1 192 0", bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid); end
    bus.imem_req_ready = 1'b1; #1;
    tick(); bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1111_2222; #1;
    tick(); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h1111_2222 || bus.inst_pc !== 32'h0040_0300) begin
      errors++; $display("FAIL hold_after_drop: got v=%b %h@%h want 1 11112222@00400300", bus.inst_valid, bus.inst, bus.inst_pc); end
    bus.inst_ready = 1'b1; flush_tgt = 32'h0040_0040; flush = 1'b1; #1;
    tick(); bus.inst_ready = 1'b0; #1;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd16) begin
      errors++; $display("FAIL hold_flush_wins: got iv=%b v=%b a=%0d want 0 1 16", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_faults();
    logic [31:0] bad [4];
    int          req_seen;
    bad = '{32'h0040_0002, 32'h003F_FFFC, 32'h0040_1000, 32'hFFFF_FFFC};
    for (int i = 0; i < 4; i++) begin
      do_reset(2);
      req_seen = 0;
      bus.imem_req_ready = 1'b1;
      flush_tgt = bad[i]; flush = 1'b1; #1;
      for (int k = 0; k < 4; k++) begin
        tick(); #1;
        if (bus.imem_req_valid === 1'b1) req_seen++;
      end
      checks++; if (fault !== 1'b1 || fault_pc !== bad[i] || req_seen != 0) begin
        errors++; $display("FAIL bad_addr_%0d: got f=%b pc=%h reqs=%0d want 1 %h 0", i, fault, fault_pc, req_seen, bad[i]); end
    end
    do_reset(2);
    flush_tgt = 32'h0040_0FFC; flush = 1'b1; #1;
    tick(); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd1023 || fault !== 1'b0) begin
      errors++; $display("FAIL last_word_ok: got v=%b a=%0d f=%b want 1 1023 0", bus.imem_req_valid, bus.imem_req_addr, fault); end
    do_reset(2);
    bus.imem_req_ready = 1'b1;
    tick(); #1;
    tick(); bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_err = 1'b1; bus.imem_rsp_data = 32'h5555_AAAA; #1;
    tick(); bus.imem_rsp_valid = 1'b0; bus.imem_rsp_err = 1'b0; #1;
    checks++; if (fault !== 1'b1 || fault_pc !== BASE || bus.inst_valid !== 1'b0) begin
      errors++; $display("FAIL bus_err_fault: got f=%b pc=%h iv=%b want 1 %h 0", fault, fault_pc, bus.inst_valid, BASE); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset(2);
    bus.imem_req_ready = 1'b1;
    tick(); #1;
    tick(); bus.imem_req_ready = 1'b0; #1;
    n = 0;
    while (fault !== 1'b1 && n < TMO + 10) begin tick(); #1; n++; end
    checks++; if (n < TMO || n > TMO + 1) begin
      errors++; $display("FAIL timeout_cycles: got %0d want %0d..%0d", n, TMO, TMO + 1); end
    flush_tgt = 32'h0040_0020; flush = 1'b1; bus.imem_req_ready = 1'b1; #1;
    tick(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h7777_7777; #1;
    tick(); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (fault !== 1'b1 || fault_pc !== BASE || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      errors++; $display("FAIL fault_terminal: got f=%b pc=%h req=%b iv=%b want 1 %h 0 0", fault, fault_pc, bus.imem_req_valid, bus.inst_valid, BASE); end
  endtask

  task automatic test_stale_after_reset();
    do_reset(2);
    bus.imem_req_ready = 1'b1;
    tick(); #1;
    tick(); bus.imem_req_ready = 1'b0; #1;
    reset = 1'b1;
    tick(); reset = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hCAFE_F00D; #1;
    tick(); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 10'd0 || bus.inst_valid !== 1'b0) begin
      errors++; $display("FAIL stale_rsp_ignored: got v=%b a=%0d iv=%b want 1 0 0", bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid); end
    tick(); #1;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1) begin
      errors++; $display("FAIL stale_rsp_later: got iv=%b req=%b want 0 1", bus.inst_valid, bus.imem_req_valid); end
  endtask

  task automatic test_back_to_back();
    int last, n;
    last = -1; n = 0;
    do_reset(2);
    auto_mem = 1'b1; lat_max = 1; rdy_pct = 100; req_rdy_pct = 100;
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1; #1;
    repeat (32) begin
      if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
        checks++; if (bus.inst !== mem_word(word_of(pc)) || bus.inst_pc !== pc) begin
          errors++; $display("FAIL b2b_data: got %h@%h want %h@%h", bus.inst, bus.inst_pc, mem_word(word_of(pc)), pc); end
        if (last >= 0) begin
          checks++; if (cyc - last != 3) begin errors++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last); end
        end
        last = cyc; n++;
      end
      tick(); #1;
    end
    checks++; if (n < 10) begin errors++; $display("FAIL b2b_count: got %0d want >=10", n); end
  endtask

  task automatic test_random_stream();
    int start_cnt, last_cons;
    do_reset(2);
    auto_mem = 1'b1; lat_max = 4; rdy_pct = 70; req_rdy_pct = 60;
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1; #1;
    start_cnt = consumed; last_cons = cyc;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(99) < 4) begin
        flush_tgt = BASE + 32'd4 * 32'($urandom_range(1023));
        flush = 1'b1;
      end
      #1;
      if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) last_cons = cyc;
      if (bus.imem_req_valid === 1'b1) begin
        checks++; if (bus.imem_req_addr !== word_of(pc)) begin
          errors++; $display("FAIL rnd_req_addr: got %0d want %0d", bus.imem_req_addr, word_of(pc)); end
      end
      if (bus.inst_valid === 1'b1) begin
        checks++; if (bus.inst_pc !== pc || bus.inst !== mem_word(word_of(pc))) begin
          errors++; $display("FAIL rnd_inst: got %h@%h want %h@%h", bus.inst, bus.inst_pc, mem_word(word_of(pc)), pc); end
      end
      checks++; if (pc_hold !== !((bus.inst_valid && bus.inst_ready) || flush) || fault !== 1'b0) begin
        errors++; $display("FAIL rnd_hold_fault: got hold=%b fault=%b", pc_hold, fault); end
      if (cyc - last_cons > 200) begin
        checks++; errors++;
        $display("FAIL rnd_progress: got no consume for %0d cycles want <=200", cyc - last_cons);
        break;
      end
    end
    checks++; if (consumed - start_cnt < 100) begin
      errors++; $display("FAIL rnd_throughput: got %0d instructions want >=100", consumed - start_cnt); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch_hold();
    test_flush_wait();
    test_flush_req_hold();
    test_faults();
    test_timeout();
    test_stale_after_reset();
    test_back_to_back();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
